// File: rtl/clocks_pkg.sv
// clocks_pkg
// Shared definitions for the clock-divider phase monitor:
//   - monitor FSM state encoding
//   - PHASE_W, the width of the divider phase
//   - DIV_RESET_PHASE, the phase the divider presents while held in reset
//   - phase_from_clocks(), which rebuilds the 3-bit divider phase from the
//     three phase-carrying divider outputs
// Optional feature macro used by this block: CLKMON_68K_CHECK_EN.
package clocks_pkg;

  localparam int PHASE_W = 3;
  localparam logic [PHASE_W-1:0] DIV_RESET_PHASE = 3'd4;

  typedef enum logic [1:0] {
    ST_UNLOCK  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_e;

  // CLK_12M is phase bit 0 and CLK_6MB is the inverse of phase bit 1.
  // CLK_1MB is high for phases 1..4, so it only gives bit 2 directly at
  // phase 4/0 (low bits 00); for every other phase it is the inverse.
  function automatic logic [PHASE_W-1:0] phase_from_clocks(
    input logic clk_12m,
    input logic clk_6mb,
    input logic clk_1mb
  );
    logic [PHASE_W-1:0] p;
    p[0] = clk_12m;
    p[1] = ~clk_6mb;
    p[2] = (p[1:0] == 2'b00) ? clk_1mb : ~clk_1mb;
    return p;
  endfunction

endpackage

// File: rtl/clk_phase_decode.sv
// clk_phase_decode
// Samples the monitored divider outputs once per CLK_24M edge and decodes
// the divider phase from the sampled bits.
// Ports:
//   i_clk       CLK_24M master clock
//   i_rst       synchronous active-high reset
//   i_clk_12m   monitored CLK_12M
//   i_clk_68k   monitored CLK_68KCLK (only with CLKMON_68K_CHECK_EN)
//   i_clk_6mb   monitored CLK_6MB
//   i_clk_1mb   monitored CLK_1MB
//   o_phase     decoded phase of the current stage-1 sample
//   o_valid     sample is self-consistent (68k clock is ~12M when checked)
// Macro CLKMON_68K_CHECK_EN: when defined, the 68k clock is sampled and
// checked; otherwise o_valid is constant 1.
module clk_phase_decode
  import clocks_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clk_12m,
`ifdef CLKMON_68K_CHECK_EN
  input  logic               i_clk_68k,
`endif
  input  logic               i_clk_6mb,
  input  logic               i_clk_1mb,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_valid
);

  logic r_s12m;
  logic r_s6mb;
  logic r_s1mb;

  // Reset values are the clock levels of phase 0, so the decode is 0
  // (and, when checked, valid) while in reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s12m <= 1'b0;
      r_s6mb <= 1'b1;
      r_s1mb <= 1'b0;
    end else begin
      r_s12m <= i_clk_12m;
      r_s6mb <= i_clk_6mb;
      r_s1mb <= i_clk_1mb;
    end
  end

  assign o_phase = phase_from_clocks(r_s12m, r_s6mb, r_s1mb);

`ifdef CLKMON_68K_CHECK_EN
  logic r_s68k;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s68k <= 1'b1;
    end else begin
      r_s68k <= i_clk_68k;
    end
  end

  assign o_valid = (r_s68k == ~r_s12m);
`else
  assign o_valid = 1'b1;
`endif

endmodule

// File: rtl/clk_phase_monitor.sv
// clk_phase_monitor
// Checks the system clock divider outputs from the CLK_24M domain: decodes
// the divider phase, locks a free-running (flywheel) phase counter onto it
// and flags every divergence once locked.
// Parameters:
//   LOCK_CYCLES  consecutive matching phases needed for lock (1..255)
//   MAX_MISS     consecutive mismatches in lock that drop lock (1..15)
//   ERR_W        width of ERR_COUNT
// Ports:
//   CLK_24M      master clock, all logic on its rising edge
//   RESETP       synchronous active-high reset
//   CLK_12M, CLK_68KCLK, CLK_6MB, CLK_1MB   monitored divider outputs
//   LOCKED       flywheel locked
//   PHASE        flywheel phase when locked, decoded phase otherwise
//   ERR          one-cycle pulse per mismatch while locked
//   ERR_COUNT    saturating mismatch count
// Macro CLKMON_68K_CHECK_EN: when defined, a 68k clock that is not the
// inverse of CLK_12M makes the sample a mismatch; otherwise CLK_68KCLK is
// ignored.
module clk_phase_monitor
  import clocks_pkg::*;
#(
  parameter int LOCK_CYCLES = 16,
  parameter int MAX_MISS    = 2,
  parameter int ERR_W       = 16
) (
  input  logic               CLK_24M,
  input  logic               RESETP,
  input  logic               CLK_12M,
  input  logic               CLK_68KCLK,
  input  logic               CLK_6MB,
  input  logic               CLK_1MB,
  output logic               LOCKED,
  output logic [PHASE_W-1:0] PHASE,
  output logic               ERR,
  output logic [ERR_W-1:0]   ERR_COUNT
);

  localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_CYCLES);
  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);

  logic [PHASE_W-1:0] w_d;
  logic               w_v;
  logic               w_match;

  clk_phase_decode u_decode (
    .i_clk     (CLK_24M),
    .i_rst     (RESETP),
    .i_clk_12m (CLK_12M),
`ifdef CLKMON_68K_CHECK_EN
    .i_clk_68k (CLK_68KCLK),
`endif
    .i_clk_6mb (CLK_6MB),
    .i_clk_1mb (CLK_1MB),
    .o_phase   (w_d),
    .o_valid   (w_v)
  );

`ifdef CLKMON_68K_CHECK_EN
`else
  logic w_unused_68k;
  assign w_unused_68k = CLK_68KCLK;
`endif

  mon_state_e         r_state;
  mon_state_e         w_state_nxt;
  logic [PHASE_W-1:0] r_pred;
  logic [PHASE_W-1:0] w_pred_nxt;
  logic [7:0]         r_match_cnt;
  logic [7:0]         w_match_nxt;
  logic [3:0]         r_miss_cnt;
  logic [3:0]         w_miss_nxt;
  logic               w_err_nxt;
  logic [ERR_W-1:0]   w_err_count_nxt;

  logic               r_locked;
  logic [PHASE_W-1:0] r_phase;
  logic               r_err;
  logic [ERR_W-1:0]   r_err_count;

  assign w_match = w_v && (w_d == r_pred);

  always_comb begin
    w_state_nxt = r_state;
    w_pred_nxt  = r_pred;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_UNLOCK: begin
        w_pred_nxt  = w_d + 3'd1;
        w_match_nxt = '0;
        w_state_nxt = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (w_match) begin
          w_match_nxt = r_match_cnt + 8'd1;
          w_pred_nxt  = r_pred + 3'd1;
          if (w_match_nxt == LOCK_LIMIT) begin
            w_state_nxt = ST_LOCKED;
            w_miss_nxt  = '0;
          end
        end else begin
          w_match_nxt = '0;
          w_pred_nxt  = w_d + 3'd1;
        end
      end
      ST_LOCKED: begin
        // Flywheel: the prediction keeps counting regardless of what the
        // decoder sees, so PHASE stays continuous through glitches.
        w_pred_nxt = r_pred + 3'd1;
        if (w_match) begin
          w_miss_nxt = '0;
        end else begin
          w_err_nxt  = 1'b1;
          w_miss_nxt = r_miss_cnt + 4'd1;
          if (w_miss_nxt == MISS_LIMIT) begin
            w_state_nxt = ST_UNLOCK;
          end
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCK;
      end
    endcase
    w_err_count_nxt = r_err_count;
    if (w_err_nxt && !(&r_err_count)) begin
      w_err_count_nxt = r_err_count + 1'b1;
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (RESETP) begin
      r_state     <= ST_UNLOCK;
      r_pred      <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_phase     <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pred      <= w_pred_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_locked    <= (r_state == ST_LOCKED);
      // While locked r_pred is the expected phase of the current sample.
      r_phase     <= (r_state == ST_LOCKED) ? r_pred : w_d;
      r_err       <= w_err_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign LOCKED    = r_locked;
  assign PHASE     = r_phase;
  assign ERR       = r_err;
  assign ERR_COUNT = r_err_count;

endmodule

// File: tb/tb_clk_phase_monitor.sv
// tb_clk_phase_monitor
// Drives a model clock divider (with fault injection) into two monitor
// instances, ERR_W=16 and ERR_W=4, and checks lock timing, phase tracking,
// error pulses, saturation, loss of lock and reset behaviour.
module tb_clk_phase_monitor;
  import clocks_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstp;
  logic       c12, c68, c6, c1;
  logic       locked, err;
  logic [2:0] phase;
  logic [15:0] err_count;
  logic       locked4, err4;
  logic [2:0] phase4;
  logic [3:0] err_count4;

  clk_phase_monitor #(.LOCK_CYCLES(16), .MAX_MISS(2), .ERR_W(16)) u_dut (
    .CLK_24M(clk), .RESETP(rstp), .CLK_12M(c12), .CLK_68KCLK(c68),
    .CLK_6MB(c6), .CLK_1MB(c1), .LOCKED(locked), .PHASE(phase),
    .ERR(err), .ERR_COUNT(err_count)
  );

  clk_phase_monitor #(.LOCK_CYCLES(16), .MAX_MISS(2), .ERR_W(4)) u_dut4 (
    .CLK_24M(clk), .RESETP(rstp), .CLK_12M(c12), .CLK_68KCLK(c68),
    .CLK_6MB(c6), .CLK_1MB(c1), .LOCKED(locked4), .PHASE(phase4),
    .ERR(err4), .ERR_COUNT(err_count4)
  );

  // Divider model and fault controls
  logic [2:0] tb_ph;
  logic       div_rst;
  logic       f_inv6, f_stuck6, f_68eq;
  logic [2:0] ph_s1, ph_s2;  // true phase sampled at the last / previous edge

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    c12 = tb_ph[0];
    c68 = f_68eq ? tb_ph[0] : ~tb_ph[0];
    c6  = f_stuck6 ? 1'b1 : (~tb_ph[1] ^ f_inv6);
    c1  = (tb_ph >= 3'd1) && (tb_ph <= 3'd4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ph_s2 = ph_s1;
    ph_s1 = tb_ph;
    if (div_rst) tb_ph = DIV_RESET_PHASE;
    else         tb_ph = tb_ph + 3'd1;
    drive();
  endtask

  // One-sample 6MB inversion while locked; checks the resulting ERR pulse.
  task automatic glitch(input int exp16, input int exp4);
    f_inv6 = 1'b1; drive();
    tick();
    f_inv6 = 1'b0; drive();
    tick();
    check_eq("glitch_err", err, 1);
    check_eq("glitch_err4", err4, 1);
    check_eq("glitch_cnt", err_count, exp16);
    check_eq("glitch_cnt4", err_count4, exp4);
    check_eq("glitch_locked", locked, 1);
    check_eq("glitch_phase", phase, ph_s2);
    tick();
    check_eq("glitch_err_end", err, 0);
    tick();
  endtask

  initial begin
    // Reset, divider held at its reset phase
    rstp = 1'b1; div_rst = 1'b1; f_inv6 = 1'b0; f_stuck6 = 1'b0; f_68eq = 1'b0;
    tb_ph = DIV_RESET_PHASE; ph_s1 = '0; ph_s2 = '0;
    drive();
    repeat (3) tick();
    check_eq("rst_locked", locked, 0);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_cnt", err_count, 0);
    check_eq("rst_cnt4", err_count4, 0);

    // Clean lock, released together with the divider
    rstp = 1'b0; div_rst = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 2)  check_eq("first_phase", phase, 4);
      if (n >= 2)  check_eq("clean_phase", phase, ph_s2);
      if (n == 18) check_eq("lock_e18", locked, 0);
      if (n == 19) check_eq("lock_e19", locked, 1);
      check_eq("clean_err", err, 0);
    end
    check_eq("clean_cnt", err_count, 0);

    // Isolated glitches while locked
    glitch(1, 1);
    glitch(2, 2);
    glitch(3, 3);

    // Reset pulse while locked; next sample is phase 3 (not the post-reset prediction)
    for (int i = 0; i < 8 && tb_ph != 3'd2; i++) tick();
    rstp = 1'b1;
    tick();
    rstp = 1'b0;
    check_eq("pulse_locked", locked, 0);
    check_eq("pulse_cnt", err_count, 0);
    check_eq("pulse_cnt4", err_count4, 0);
    check_eq("pulse_phase", phase, 0);
    for (int n = 1; n <= 19; n++) begin
      tick();
      if (n == 18) check_eq("relock_e18", locked, 0);
      if (n == 19) check_eq("relock_e19", locked, 1);
    end

    // 20 isolated glitches: 16-bit count tracks, 4-bit count saturates at 15
    for (int i = 1; i <= 20; i++) glitch(i, (i > 15) ? 15 : i);

    // 6MB stuck high: phases 2 and 3 mismatch back to back -> loss of lock
    for (int i = 0; i < 8 && tb_ph != 3'd2; i++) tick();
    f_stuck6 = 1'b1; drive();
    tick();
    tick();
    check_eq("stuck_err1", err, 1);
    check_eq("stuck_lock1", locked, 1);
    check_eq("stuck_cnt1", err_count, 21);
    tick();
    check_eq("stuck_err2", err, 1);
    check_eq("stuck_lock2", locked, 1);
    check_eq("stuck_cnt2", err_count, 22);
    tick();
    check_eq("stuck_unlock", locked, 0);
    check_eq("stuck_err3", err, 0);
    check_eq("stuck_cnt4", err_count4, 15);
    for (int n = 0; n < 40; n++) begin
      tick();
      check_eq("stuck_norelock", locked, 0);
    end

    // 68k clock driven equal to 12M, fresh reset with the divider
    f_stuck6 = 1'b0; f_68eq = 1'b1;
    rstp = 1'b1; div_rst = 1'b1; tb_ph = DIV_RESET_PHASE; drive();
    repeat (2) tick();
    check_eq("rst2_cnt", err_count, 0);
    rstp = 1'b0; div_rst = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      tick();
      if (n == 18) check_eq("k68_e18", locked, 0);
`ifdef CLKMON_68K_CHECK_EN
      if (n == 19) check_eq("k68_e19", locked, 0);
`else
      if (n == 19) check_eq("k68_e19", locked, 1);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
